bin_to_bcd_seq: RTL



---
 rtl/bin_to_bcd_seq.sv | 88 ++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary to 4-digit packed BCD, one input bit per clock.
// Define BIN_TO_BCD_SATURATE_EN to clamp out-of-range results to 16'h9999.

module bin_to_bcd_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bin_to_bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd,
  output logic             overflow
);
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [BIN_W-1:0] shreg;
  logic [19:0]      scratch;
  logic [19:0]      adj;
  logic [19:0]      nxt;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      res;

  // Per-digit add-3 correction ahead of the shift keeps every nibble decimal.
  for (genvar i = 0; i < 5; i++) begin : g_adj
    bin_to_bcd_adj3 u_adj (.din(scratch[4*i +: 4]), .dout(adj[4*i +: 4]));
  end

  assign nxt = {adj[18:0], shreg[BIN_W-1]};

`ifdef BIN_TO_BCD_SATURATE_EN
  assign res = (nxt[19:16] != 4'd0) ? 16'h9999 : nxt[15:0];
`else
  assign res = nxt[15:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= 16'h0000;
      overflow <= 1'b0;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= nxt;
          shreg   <= {shreg[BIN_W-2:0], 1'b0};
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            overflow <= (nxt[19:16] != 4'd0);
            bcd      <= res;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
